// File: rtl/aqed_fifo_pkg.sv
// Shared types and widths for the A-QED FIFO write-side feeder.
package aqed_fifo_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_PASS  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              dup;
  } out_beat_t;

  // Write-index increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/aqed_out_stage.sv
// One-entry output register in front of the FIFO write port; holds its beat while full.
module aqed_out_stage
  import aqed_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  out_beat_t         beat_i,
  input  logic              full_i,
  output logic              load_ok_c,
  output logic              wen_c,
  output logic [DATA_W-1:0] data_o,
  output logic              dup_o
);

  out_beat_t beat_q, beat_d;

  always_comb begin
    wen_c     = beat_q.valid & ~full_i;
    load_ok_c = ~beat_q.valid | wen_c;
    data_o    = beat_q.data;
    dup_o     = beat_q.dup;
  end

  // Drain on write; a load in the same cycle replaces the draining beat.
  always_comb begin
    beat_d = beat_q;
    if (wen_c) begin
      beat_d.valid = 1'b0;
    end
    if (load_i) begin
      beat_d = beat_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_q <= '0;
    end else begin
      beat_q <= beat_d;
    end
  end

endmodule

// File: rtl/aqed_fifo_feeder.sv
// A-QED write-side feeder: forwards upstream beats, captures one original and re-injects it once.
module aqed_fifo_feeder
  import aqed_fifo_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              capture_en,
  input  logic              exec_dup,
  input  logic              full,
  output logic              wen_out,
  output logic [DATA_W-1:0] data_out,
  output logic              dup_flag,
  output logic [CNT_W-1:0]  orig_idx,
  output logic [CNT_W-1:0]  dup_idx,
  output logic              orig_valid,
  output logic              dup_valid,
  output logic [CNT_W-1:0]  wr_count
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [CNT_W-1:0]  orig_idx_q, orig_idx_d;
  logic [CNT_W-1:0]  dup_idx_q, dup_idx_d;
  logic              orig_valid_q, orig_valid_d;
  logic              dup_valid_q, dup_valid_d;
  logic [CNT_W-1:0]  wr_count_q, wr_count_d;

  logic              load_ok;
  logic              stage_dup;
  logic              dup_take;
  logic              fire;
  logic              load;
  out_beat_t         load_beat;
  logic [CNT_W-1:0]  next_idx;

  aqed_out_stage u_out_stage (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .beat_i    (load_beat),
    .full_i    (full),
    .load_ok_c (load_ok),
    .wen_c     (wen_out),
    .data_o    (data_out),
    .dup_o     (stage_dup)
  );

  // The duplicate wins the output register over upstream in the cycle it is taken.
  always_comb begin
    dup_take        = (state_q == ST_ARMED) & exec_dup & load_ok;
    in_ready        = load_ok & ~dup_take;
    fire            = in_valid & in_ready;
    load            = fire | dup_take;
    load_beat.valid = 1'b1;
    load_beat.data  = dup_take ? cap_q : in_data;
    load_beat.dup   = dup_take;
    dup_flag        = stage_dup & wen_out;
    next_idx        = wen_out ? sat_inc(wr_count_q) : wr_count_q;
  end

  always_comb begin
    state_d      = state_q;
    cap_d        = cap_q;
    orig_idx_d   = orig_idx_q;
    dup_idx_d    = dup_idx_q;
    orig_valid_d = orig_valid_q;
    dup_valid_d  = dup_valid_q;
    wr_count_d   = next_idx;
    if (wen_out & stage_dup) begin
      dup_valid_d = 1'b1;
    end
    case (state_q)
      ST_PASS: begin
        if (fire & capture_en) begin
          cap_d        = in_data;
          orig_idx_d   = next_idx;
          orig_valid_d = 1'b1;
          state_d      = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (dup_take) begin
          dup_idx_d = next_idx;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_PASS;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_PASS;
      cap_q        <= '0;
      orig_idx_q   <= '0;
      dup_idx_q    <= '0;
      orig_valid_q <= 1'b0;
      dup_valid_q  <= 1'b0;
      wr_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      cap_q        <= cap_d;
      orig_idx_q   <= orig_idx_d;
      dup_idx_q    <= dup_idx_d;
      orig_valid_q <= orig_valid_d;
      dup_valid_q  <= dup_valid_d;
      wr_count_q   <= wr_count_d;
    end
  end

  assign orig_idx   = orig_idx_q;
  assign dup_idx    = dup_idx_q;
  assign orig_valid = orig_valid_q;
  assign dup_valid  = dup_valid_q;
  assign wr_count   = wr_count_q;

endmodule
